traffic_gen: RTL and testbench
==============================

TRAFFIC_GEN -- requirements
Module: traffic_gen

Interface
REQ-001: Parameter WIDTH, default 8, is the packet data width in bits.
REQ-002: Parameter LENW, default 4, is the width of the burst and gap length fields.
REQ-003: Parameter CNTW, default 16, is the width of the packet index counter.
REQ-004: Parameter SEED, default 0, is the first data value emitted after reset.
REQ-005: Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-006: Port rst, input, 1 bit, is a synchronous active-high reset.
REQ-007: Port enable, input, 1 bit, permits traffic generation.
REQ-008: Port burst_len, input, LENW bits, is the number of pushes per burst.
REQ-009: Port gap_len, input, LENW bits, is the number of idle cycles between bursts.
REQ-010: Port magic_idx, input, CNTW bits, is the index of the packet to tag with start.
REQ-011: Port full, input, 1 bit, is the downstream FIFO full flag.
REQ-012: Port push, output, 1 bit, is the FIFO write strobe.
REQ-013: Port start, output, 1 bit, is the magic-packet tag for the scoreboard.
REQ-014: Port data_out, output, WIDTH bits, is the packet data presented with push.
REQ-015: Port pkt_cnt, output, CNTW bits, is the number of packets pushed since reset (wraps).
REQ-016: Port magic_sent, output, 1 bit, is a sticky flag set once the tagged packet has been pushed.

Function
REQ-017: The block SHALL implement FSM states IDLE, BURST and GAP.
REQ-018: IDLE SHALL go to BURST on enable=1, latching burst_len and gap_len into internal registers; the block SHALL use only the latched values until the next IDLE exit.
REQ-019: A latched burst_len of 0 SHALL be treated as 1.
REQ-020: push SHALL be combinational: push = (state==BURST) & enable & ~full; push SHALL never be 1 while full=1.
REQ-021: data_out SHALL equal the internal sequence register in every cycle; the sequence register SHALL increment by 1, modulo 2^WIDTH, on each cycle with push=1.
REQ-022: pkt_cnt SHALL increment by 1, modulo 2^CNTW, on each cycle with push=1.
REQ-023: In BURST, the burst counter SHALL advance only on push.
REQ-024: On the push that completes burst_len pushes, the FSM SHALL go to GAP if the latched gap_len is nonzero; otherwise it SHALL stay in BURST with the burst counter cleared.
REQ-025: GAP SHALL last exactly gap_len cycles with push=0, then return to BURST with the burst counter cleared.
REQ-026: full=1 in BURST SHALL stall the burst counter, sequence and pkt_cnt, and SHALL NOT consume gap time.
REQ-027: enable=0 in BURST or GAP SHALL force push=0 in that same cycle, and the FSM SHALL go to IDLE on the next edge.
REQ-028: On that return to IDLE, the sequence register, pkt_cnt and magic_sent SHALL keep their values.
REQ-029: start SHALL be combinational: start = push & (pkt_cnt==magic_idx) & ~magic_sent.
REQ-030: start SHALL therefore be asserted for at most one push after reset, including after pkt_cnt wraps.
REQ-031: magic_sent SHALL set on the edge following a cycle with start=1 and SHALL remain set until reset.
REQ-032: Outputs SHALL have no X in any cycle after the first reset edge.

Reset
REQ-033: On a clock edge with rst=1, the block SHALL set state=IDLE, sequence=SEED, pkt_cnt=0, magic_sent=0, and clear the burst and gap counters.
REQ-034: During rst=1 and in IDLE, push=0 and start=0.
REQ-035: rst SHALL take priority over all other inputs, including mid-burst and mid-gap.

Verification
REQ-036: Scenario 1: burst_len=3, gap_len=2, full=0, enable=1 from cycle 0 after reset -> push pattern 1,1,1,0,0,1,1,1,0,0; data_out 0,1,2 on the first burst, then 3,4,5.
REQ-037: Scenario 2: magic_idx=4, burst_len=2, gap_len=1 -> start=1 only with data_out=4; magic_sent=1 from the following cycle; no further start through 2^CNTW+8 pushes (CNTW=4 build).
REQ-038: Scenario 3: full held 1 for 5 cycles mid-burst -> push=0 throughout, with data_out, pkt_cnt and the burst position frozen; the burst resumes with the next sequence value.
REQ-039: Scenario 4: gap_len=0, burst_len=0 -> push=1 every unstalled cycle, with data incrementing each cycle.
REQ-040: Scenario 5: enable dropped mid-burst after 2 of 4 pushes, then re-raised -> push=0 in the drop cycle, IDLE next; on re-entry a fresh 4-push burst with the sequence continuing.
REQ-041: Scenario 6: rst asserted in GAP with pkt_cnt=7 -> next cycle IDLE, pkt_cnt=0, data_out=SEED, magic_sent=0.
REQ-042: Connected to fifo and Scoreboard (data_in=data_out, start=start, pop constrained to ~empty), random full/enable/config -> prop_signal=1 every cycle.

Source files
------------

// File: rtl/traffic_gen.sv
// Burst/gap packet traffic generator feeding a FIFO, with a one-shot
// magic-packet tag for downstream scoreboarding.
module traffic_gen #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4,
    parameter int CNTW  = 16,
    parameter int SEED  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [LENW-1:0] burst_len,
    input  logic [LENW-1:0] gap_len,
    input  logic [CNTW-1:0] magic_idx,
    input  logic            full,
    output logic            push,
    output logic            start,
    output logic [WIDTH-1:0] data_out,
    output logic [CNTW-1:0] pkt_cnt,
    output logic            magic_sent
);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LENW-1:0]  r_blen;
    logic [LENW-1:0]  r_glen;
    logic [LENW-1:0]  r_bcnt;
    logic [LENW-1:0]  r_gcnt;
    logic [WIDTH-1:0] r_seq;
    logic [CNTW-1:0]  r_cnt;
    logic             r_sent;

    logic [LENW-1:0]  w_bcnt_nxt;
    logic [LENW-1:0]  w_gcnt_nxt;
    logic [LENW-1:0]  w_blen_m1;
    logic             w_latch;
    logic             w_push;
    logic             w_start;

    // A zero burst length behaves as a single-push burst.
    assign w_blen_m1 = (r_blen == '0) ? '0 : r_blen - LENW'(1);

    // Reset gating keeps push low while rst is held, even mid-burst.
    assign w_push  = (r_state == BURST) & enable & ~full & ~rst;
    assign w_start = w_push & (r_cnt == magic_idx) & ~r_sent;

    assign push       = w_push;
    assign start      = w_start;
    assign data_out   = r_seq;
    assign pkt_cnt    = r_cnt;
    assign magic_sent = r_sent;

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_gcnt_nxt  = r_gcnt;
        w_latch     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = BURST;
                    w_latch     = 1'b1;
                    w_bcnt_nxt  = '0;
                    w_gcnt_nxt  = '0;
                end
            end
            BURST: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_push) begin
                    if (r_bcnt == w_blen_m1) begin
                        w_bcnt_nxt = '0;
                        if (r_glen != '0) begin
                            w_state_nxt = GAP;
                            w_gcnt_nxt  = '0;
                        end
                    end else begin
                        w_bcnt_nxt = r_bcnt + LENW'(1);
                    end
                end
            end
            GAP: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (r_gcnt == r_glen - LENW'(1)) begin
                    w_state_nxt = BURST;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_gcnt_nxt = r_gcnt + LENW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_blen  <= '0;
            r_glen  <= '0;
            r_bcnt  <= '0;
            r_gcnt  <= '0;
            r_seq   <= WIDTH'(SEED);
            r_cnt   <= '0;
            r_sent  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            if (w_latch) begin
                r_blen <= burst_len;
                r_glen <= gap_len;
            end
            if (w_push) begin
                r_seq <= r_seq + WIDTH'(1);
                r_cnt <= r_cnt + CNTW'(1);
            end
            if (w_start) begin
                r_sent <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_gen.sv
// Bench for traffic_gen: directed scenarios plus randomised traffic,
// checked every cycle against a burst/gap counting model.
module tb_traffic_gen;

    localparam int WIDTH = 8;
    localparam int LENW  = 4;
    localparam int CNTW  = 4;
    localparam int SEED  = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             full;
    logic [LENW-1:0]  burst_len;
    logic [LENW-1:0]  gap_len;
    logic [CNTW-1:0]  magic_idx;
    logic             push;
    logic             start;
    logic [WIDTH-1:0] data_out;
    logic [CNTW-1:0]  pkt_cnt;
    logic             magic_sent;

    traffic_gen #(
        .WIDTH(WIDTH),
        .LENW (LENW),
        .CNTW (CNTW),
        .SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .magic_idx (magic_idx),
        .full      (full),
        .push      (push),
        .start     (start),
        .data_out  (data_out),
        .pkt_cnt   (pkt_cnt),
        .magic_sent(magic_sent)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: pushes left in the current burst, idle cycles left in gap.
    bit               m_ok  = 1'b0;
    bit               m_act = 1'b0;
    int               m_left = 0;
    int               m_gap  = 0;
    int               m_bl   = 1;
    int               m_gl   = 0;
    logic [WIDTH-1:0] m_seq  = '0;
    logic [CNTW-1:0]  m_cnt  = '0;
    bit               m_sent = 1'b0;

    function automatic bit f_push();
        return m_ok && m_act && (m_gap == 0) && enable && !full && !rst;
    endfunction

    function automatic bit f_start();
        return f_push() && (m_cnt == magic_idx) && !m_sent;
    endfunction

    always @(posedge clk) begin : mdl
        bit ep;
        bit es;
        ep = f_push();
        es = f_start();
        if (rst) begin
            m_ok   = 1'b1;
            m_act  = 1'b0;
            m_seq  = WIDTH'(SEED);
            m_cnt  = '0;
            m_sent = 1'b0;
            m_left = 0;
            m_gap  = 0;
        end else if (!m_act) begin
            if (enable) begin
                m_act  = 1'b1;
                m_bl   = (burst_len == 0) ? 1 : int'(burst_len);
                m_gl   = int'(gap_len);
                m_left = m_bl;
                m_gap  = 0;
            end
        end else if (!enable) begin
            m_act = 1'b0;
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_left = m_bl;
        end else if (ep) begin
            m_seq++;
            m_cnt++;
            if (es) m_sent = 1'b1;
            m_left--;
            if (m_left == 0) begin
                m_left = m_bl;
                m_gap  = m_gl;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("push", push, f_push());
            chk("start", start, f_start());
            chk("data_out", data_out, m_seq);
            chk("pkt_cnt", pkt_cnt, m_cnt);
            chk("magic_sent", magic_sent, m_sent);
        end
    end

    logic             s_push;
    logic             s_start;
    logic             s_sent;
    logic [WIDTH-1:0] s_data;
    logic [CNTW-1:0]  s_cnt;

    // Inputs set before a call apply to that cycle; outputs sampled mid-cycle.
    task automatic cyc();
        @(negedge clk);
        s_push  = push;
        s_start = start;
        s_sent  = magic_sent;
        s_data  = data_out;
        s_cnt   = pkt_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        full   = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        logic [WIDTH-1:0] dq[$];
        int npush;
        int nstart;
        int budget;
        bit prev_start;
        bit ok;
        logic [WIDTH-1:0] sd;
        logic sent_after;

        rst       = 1'b1;
        enable    = 1'b0;
        full      = 1'b0;
        burst_len = '0;
        gap_len   = '0;
        magic_idx = '0;

        // Scenario 1: 3-push bursts, 2-cycle gaps.
        do_reset();
        burst_len = 4'd3;
        gap_len   = 4'd2;
        magic_idx = 4'd15;
        enable    = 1'b1;
        cyc();
        chk("s1_idle_push", s_push, 1'b0);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            pat[9-i] = s_push;
            if (s_push) dq.push_back(s_data);
        end
        chk("s1_pattern", pat, 10'b1110011100);
        chk("s1_npush", dq.size(), 6);
        for (int i = 0; i < dq.size(); i++) chk("s1_data", dq[i], i);

        // Scenario 2: magic tag fires once, even across pkt_cnt wrap.
        do_reset();
        burst_len  = 4'd2;
        gap_len    = 4'd1;
        magic_idx  = 4'd4;
        enable     = 1'b1;
        npush      = 0;
        nstart     = 0;
        budget     = 0;
        prev_start = 1'b0;
        sd         = '1;
        sent_after = 1'b0;
        while (npush < 24 && budget < 200) begin
            cyc();
            budget++;
            if (prev_start) sent_after = s_sent;
            prev_start = s_start;
            if (s_push) npush++;
            if (s_start) begin
                nstart++;
                sd = s_data;
            end
        end
        chk("s2_reach_pushes", npush, 24);
        chk("s2_nstart", nstart, 1);
        chk("s2_start_data", sd, 8'd4);
        chk("s2_sent_after", sent_after, 1'b1);

        // Scenario 3: full stall mid-burst.
        do_reset();
        burst_len = 4'd4;
        gap_len   = 4'd1;
        enable    = 1'b1;
        cyc();
        cyc();
        cyc();
        full = 1'b1;
        ok   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (s_push !== 1'b0 || s_data !== 8'd2 || s_cnt !== 4'd2)
                ok = 1'b0;
        end
        chk("s3_stall_frozen", ok, 1'b1);
        full = 1'b0;
        cyc();
        chk("s3_resume_push", s_push, 1'b1);
        chk("s3_resume_data", s_data, 8'd2);
        cyc();
        chk("s3_last_push", s_push, 1'b1);
        cyc();
        chk("s3_gap_after", s_push, 1'b0);

        // Scenario 4: zero burst and gap -> continuous pushes.
        do_reset();
        burst_len = 4'd0;
        gap_len   = 4'd0;
        enable    = 1'b1;
        cyc();
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (s_push !== 1'b1 || s_data !== WIDTH'(i)) ok = 1'b0;
        end
        chk("s4_continuous", ok, 1'b1);
        full = 1'b1;
        cyc();
        chk("s4_full_push", s_push, 1'b0);
        full = 1'b0;
        cyc();
        chk("s4_after_full", s_data, 8'd8);

        // Scenario 5: enable drop mid-burst, then fresh burst.
        do_reset();
        burst_len = 4'd4;
        gap_len   = 4'd3;
        enable    = 1'b1;
        cyc();
        cyc();
        cyc();
        enable = 1'b0;
        cyc();
        chk("s5_drop_push", s_push, 1'b0);
        enable = 1'b1;
        cyc();
        chk("s5_idle_push", s_push, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (s_push !== 1'b1 || s_data !== WIDTH'(i + 2)) ok = 1'b0;
        end
        chk("s5_fresh_burst", ok, 1'b1);
        cyc();
        chk("s5_gap", s_push, 1'b0);

        // Scenario 6: reset while in gap.
        do_reset();
        burst_len = 4'd7;
        gap_len   = 4'd3;
        magic_idx = 4'd2;
        enable    = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        chk("s6_pre_cnt", s_cnt, 4'd7);
        chk("s6_pre_sent", s_sent, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("s6_cnt", s_cnt, 4'd0);
        chk("s6_data", s_data, 8'(SEED));
        chk("s6_sent", s_sent, 1'b0);
        chk("s6_push", s_push, 1'b0);

        // Randomised traffic, config and occasional reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            full   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                burst_len = LENW'($urandom_range(0, 15));
                gap_len   = LENW'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 299) == 0);
            if (rst) magic_idx = CNTW'($urandom_range(0, 15));
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
